// File: rtl/dht11_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dht11_pkg
//  Purpose  : Shared types and constants for the DHT11 sensor-side responder:
//             FSM state encoding, frame geometry and the frame checksum.
//  Revision : 1.0  initial release
// ============================================================================
package dht11_pkg;

  localparam int FRAME_BITS = 40;
  localparam int BYTE_W     = 8;
  localparam int US_CNT_W   = 15;
  localparam int BIT_IDX_W  = 6;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_START_LOW = 4'd1,
    ST_WAIT_REL  = 4'd2,
    ST_RESP_DLY  = 4'd3,
    ST_RESP_LO   = 4'd4,
    ST_RESP_HI   = 4'd5,
    ST_BIT_LO    = 4'd6,
    ST_BIT_HI    = 4'd7,
    ST_END_LO    = 4'd8
  } state_t;

  // Checksum byte: sum of the four data bytes, modulo 256.
  function automatic logic [BYTE_W-1:0] dht11_checksum(
    input logic [BYTE_W-1:0] b0,
    input logic [BYTE_W-1:0] b1,
    input logic [BYTE_W-1:0] b2,
    input logic [BYTE_W-1:0] b3
  );
    logic [BYTE_W+1:0] sum;
    sum = 10'(b0) + 10'(b1) + 10'(b2) + 10'(b3);
    return sum[BYTE_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/dht11_responder_us_timer.sv
`default_nettype none
// ============================================================================
//  Module   : dht11_us_timer
//  Purpose  : Microsecond timebase. A prescaler divides clk down to a one-cycle
//             us_tick; a saturating counter counts elapsed microseconds. clr
//             restarts both so that the owner sees exact N-microsecond windows.
//  Revision : 1.0  initial release
// ============================================================================
module dht11_us_timer
  import dht11_pkg::*;
#(
  parameter int CLKS_PER_US = 50
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  output logic                us_tick,
  output logic [US_CNT_W-1:0] count
);

  localparam int PRESC_W = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLKS_PER_US - 1);

  logic [PRESC_W-1:0]  presc_q, presc_d;
  logic [US_CNT_W-1:0] count_q, count_d;
  logic                tick;

  // Prescaler wrap, saturating us count, clear has priority.
  always_comb begin
    tick    = (presc_q == PRESC_LAST);
    presc_d = tick ? '0 : presc_q + PRESC_W'(1);
    count_d = count_q;
    if (tick && (count_q != '1)) begin
      count_d = count_q + US_CNT_W'(1);
    end
    if (clr) begin
      presc_d = '0;
      count_d = '0;
    end
  end

  // Timebase registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      count_q <= '0;
    end else begin
      presc_q <= presc_d;
      count_q <= count_d;
    end
  end

  assign us_tick = tick;
  assign count   = count_q;

endmodule
`default_nettype wire

// File: rtl/dht11_responder.sv
`default_nettype none
// ============================================================================
//  Module   : dht11_responder
//  Purpose  : DHT11 sensor emulator on the open-drain DQ wire. Detects the host
//             start pulse, sends the presence sequence and then the 40-bit
//             humidity/temperature/checksum frame, MSB first.
//  Revision : 1.0  initial release
// ============================================================================
module dht11_responder
  import dht11_pkg::*;
#(
  parameter int CLKS_PER_US   = 50,
  parameter int START_MIN_US  = 18000,
  parameter int RESP_DELAY_US = 30,
  parameter int RESP_LOW_US   = 80,
  parameter int RESP_HIGH_US  = 80,
  parameter int BIT_LOW_US    = 50,
  parameter int BIT0_HIGH_US  = 27,
  parameter int BIT1_HIGH_US  = 70
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dq_in,
  output logic              dq_oe,
  input  logic [BYTE_W-1:0] hum_int,
  input  logic [BYTE_W-1:0] hum_dec,
  input  logic [BYTE_W-1:0] temp_int,
  input  logic [BYTE_W-1:0] temp_dec,
  output logic              busy,
  output logic              frame_done,
  output logic              start_err
);

  localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(FRAME_BITS - 1);

  // Terminal counts: a timed state ends on the tick that completes its last us.
  localparam logic [US_CNT_W-1:0] TC_START = US_CNT_W'(START_MIN_US - 1);
  localparam logic [US_CNT_W-1:0] TC_RDLY  = US_CNT_W'(RESP_DELAY_US - 1);
  localparam logic [US_CNT_W-1:0] TC_RLO   = US_CNT_W'(RESP_LOW_US - 1);
  localparam logic [US_CNT_W-1:0] TC_RHI   = US_CNT_W'(RESP_HIGH_US - 1);
  localparam logic [US_CNT_W-1:0] TC_BLO   = US_CNT_W'(BIT_LOW_US - 1);
  localparam logic [US_CNT_W-1:0] TC_B0HI  = US_CNT_W'(BIT0_HIGH_US - 1);
  localparam logic [US_CNT_W-1:0] TC_B1HI  = US_CNT_W'(BIT1_HIGH_US - 1);

  logic                  dq_meta_q, dq_s_q;
  state_t                state_q, state_d;
  logic [BIT_IDX_W-1:0]  bit_idx_q, bit_idx_d;
  logic [FRAME_BITS-1:0] shreg_q, shreg_d;
  logic                  dq_oe_q, dq_oe_d;
  logic                  busy_q, busy_d;
  logic                  frame_done_q, frame_done_d;
  logic                  start_err_q, start_err_d;

  logic                  timer_clr;
  logic                  us_tick;
  logic [US_CNT_W-1:0]   us_cnt;
  logic [US_CNT_W-1:0]   us_target;
  logic                  timed_done;
  logic [BYTE_W-1:0]     checksum;

  dht11_us_timer #(
    .CLKS_PER_US (CLKS_PER_US)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (timer_clr),
    .us_tick (us_tick),
    .count   (us_cnt)
  );

  assign checksum = dht11_checksum(hum_int, hum_dec, temp_int, temp_dec);

  // Select the duration of the current timed state and flag its last cycle.
  always_comb begin
    us_target = '0;
    case (state_q)
      ST_START_LOW: us_target = TC_START;
      ST_RESP_DLY:  us_target = TC_RDLY;
      ST_RESP_LO:   us_target = TC_RLO;
      ST_RESP_HI:   us_target = TC_RHI;
      ST_BIT_LO:    us_target = TC_BLO;
      ST_BIT_HI:    us_target = shreg_q[FRAME_BITS-1] ? TC_B1HI : TC_B0HI;
      ST_END_LO:    us_target = TC_BLO;
      default:      us_target = '0;
    endcase
    timed_done = us_tick && (us_cnt == us_target);
  end

  // Next-state, frame shifter and output decode.
  always_comb begin
    state_d      = state_q;
    bit_idx_d    = bit_idx_q;
    shreg_d      = shreg_q;
    start_err_d  = 1'b0;
    frame_done_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!dq_s_q) state_d = ST_START_LOW;
      end
      ST_START_LOW: begin
        // A release before the minimum has elapsed is a rejected start.
        if (dq_s_q) begin
          start_err_d = 1'b1;
          state_d     = ST_IDLE;
        end else if (timed_done) begin
          state_d = ST_WAIT_REL;
        end
      end
      ST_WAIT_REL: begin
        // Data bytes are sampled only here; the frame carries this snapshot.
        if (dq_s_q) begin
          shreg_d   = {hum_int, hum_dec, temp_int, temp_dec, checksum};
          bit_idx_d = '0;
          state_d   = ST_RESP_DLY;
        end
      end
      ST_RESP_DLY: if (timed_done) state_d = ST_RESP_LO;
      ST_RESP_LO:  if (timed_done) state_d = ST_RESP_HI;
      ST_RESP_HI:  if (timed_done) state_d = ST_BIT_LO;
      ST_BIT_LO:   if (timed_done) state_d = ST_BIT_HI;
      ST_BIT_HI: begin
        if (timed_done) begin
          if (bit_idx_q == LAST_BIT) begin
            state_d = ST_END_LO;
          end else begin
            bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
            shreg_d   = {shreg_q[FRAME_BITS-2:0], 1'b0};
            state_d   = ST_BIT_LO;
          end
        end
      end
      ST_END_LO: begin
        if (timed_done) begin
          frame_done_d = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so they register with it.
    dq_oe_d = (state_d == ST_RESP_LO) || (state_d == ST_BIT_LO) ||
              (state_d == ST_END_LO);
    busy_d  = (state_d == ST_RESP_DLY) || (state_d == ST_RESP_LO) ||
              (state_d == ST_RESP_HI)  || (state_d == ST_BIT_LO)  ||
              (state_d == ST_BIT_HI)   || (state_d == ST_END_LO);

    // Restart the timebase on every state change.
    timer_clr = (state_d != state_q);
  end

  // Synchronizer, FSM and registered outputs; reset releases DQ at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dq_meta_q    <= 1'b1;
      dq_s_q       <= 1'b1;
      state_q      <= ST_IDLE;
      bit_idx_q    <= '0;
      shreg_q      <= '0;
      dq_oe_q      <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      start_err_q  <= 1'b0;
    end else begin
      dq_meta_q    <= dq_in;
      dq_s_q       <= dq_meta_q;
      state_q      <= state_d;
      bit_idx_q    <= bit_idx_d;
      shreg_q      <= shreg_d;
      dq_oe_q      <= dq_oe_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      start_err_q  <= start_err_d;
    end
  end

  assign dq_oe      = dq_oe_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign start_err  = start_err_q;

endmodule
`default_nettype wire
